// File: rtl/acc_sequencer.sv
// Key-driven sequencer for a four-function calculator: steps operand A, operator,
// operand B and result through the accumulator, steering the external mux and ALU.
module acc_sequencer #(
  parameter int WIDTH   = 16,
  parameter int DIGIT_W = 4
) (
  input  logic             inClk,
  input  logic             inResetN,
  input  logic [WIDTH-1:0] inMux,
  input  logic             inAluCarry,
  input  logic             inDigitValid,
  input  logic             inOpValid,
  input  logic [1:0]       inOp,
  input  logic             inClear,
  output logic             outSelect,
  output logic             outRegLoad,
  output logic [1:0]       outAluOp,
  output logic [WIDTH-1:0] outAcc,
  output logic             outOverflow,
  output logic             outBusy,
  output logic             outDone,
  output logic [2:0]       outState
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    WAIT_OP = 3'd2,
    WAIT_B  = 3'd3,
    EXEC    = 3'd4,
    RESULT  = 3'd5
  } stateT;

  stateT state;

  logic keyOk;
  logic digitTake;
  logic opTake;

  // Key strobes are single-cycle valid pulses with no ready: a strobe is either
  // taken in the cycle it is present or dropped. Priority is clear > digit > op.
  assign keyOk     = (state != LOAD_A) && (state != EXEC);
  assign digitTake = inResetN && inDigitValid && !inClear && keyOk;
  assign opTake    = inResetN && inOpValid && !inDigitValid && !inClear && keyOk;

  assign outRegLoad = digitTake;
  assign outSelect  = (state == EXEC);
  assign outBusy    = !keyOk;
  assign outDone    = (state == RESULT);
  assign outState   = state;

  always_ff @(posedge inClk or negedge inResetN) begin
    if (!inResetN) begin
      state       <= IDLE;
      outAcc      <= '0;
      outAluOp    <= 2'b00;
      outOverflow <= 1'b0;
    end else if (inClear) begin
      state       <= IDLE;
      outAcc      <= '0;
      outAluOp    <= 2'b00;
      outOverflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (digitTake) state <= LOAD_A;
        end
        LOAD_A: begin
          outAcc      <= inMux;
          outOverflow <= 1'b0;
          state       <= WAIT_OP;
        end
        WAIT_OP: begin
          if (digitTake) begin
            state <= LOAD_A;
          end else if (opTake) begin
            outAluOp <= inOp;
            state    <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (digitTake) begin
            state <= EXEC;
          end else if (opTake) begin
            outAluOp <= inOp;
          end
        end
        EXEC: begin
          outAcc      <= inMux;
          outOverflow <= outOverflow | inAluCarry;
          state       <= RESULT;
        end
        RESULT: begin
          // An operator here chains on the held result; a digit starts afresh.
          if (digitTake) begin
            state <= LOAD_A;
          end else if (opTake) begin
            outAluOp <= inOp;
            state    <= WAIT_B;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand A comes from the digit register, so the mux must zero-extend it.
  digit_zero_ext: assert property (@(posedge inClk) disable iff (!inResetN)
    (state == LOAD_A) |-> ((inMux >> DIGIT_W) == '0));

endmodule

// File: doc/acc_sequencer.md
ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 Parameter: WIDTH, 16, accumulator and mux-output width.
REQ-002 Parameter: DIGIT_W, 4, keypad digit width.
REQ-003 Ports (clock and reset first):
- inClk  input  1  single clock; all state changes on the rising edge.
- inResetN  input  1  asynchronous, active-low reset.
- inMux  input  WIDTH  output of the ACC-side mux (digit or ALU result).
- inAluCarry  input  1  ALU carry/overflow for the current operation.
- inDigitValid  input  1  one-cycle strobe: a digit key was pressed.
- inOpValid  input  1  one-cycle strobe: an operator key was pressed.
- inOp  input  2  operator code, sampled when inOpValid=1.
- inClear  input  1  one-cycle strobe: clear key.
- outSelect  output  1  mux select; 0 = input register, 1 = ALU.
- outRegLoad  output  1  load enable for the 4-bit input register.
- outAluOp  output  2  latched operator driven to the ALU.
- outAcc  output  WIDTH  accumulator value; also drives the ALU A operand.
- outOverflow  output  1  sticky overflow flag.
- outBusy  output  1  high while a key strobe cannot be accepted.
- outDone  output  1  high while a computed result is held.

Function
REQ-004 The FSM SHALL have states IDLE, LOAD_A, WAIT_OP, WAIT_B, EXEC and RESULT.
REQ-005 Key priority SHALL be clear > digit > op when strobes coincide; lower-priority strobes in the same cycle are dropped.
REQ-006 inClear SHALL, from any state, force IDLE on the next edge with outAcc=0, outAluOp=0 and outOverflow=0.
REQ-007 IDLE: a digit strobe SHALL assert outRegLoad that cycle and move to LOAD_A. An op strobe SHALL be ignored.
REQ-008 LOAD_A: outSelect=0; outAcc SHALL load inMux (the digit, zero-extended by the mux) and clear outOverflow. Next state is WAIT_OP.
REQ-009 WAIT_OP: an op strobe SHALL latch inOp into outAluOp and move to WAIT_B. A digit strobe SHALL assert outRegLoad and return to LOAD_A, replacing operand A.
REQ-010 WAIT_B: a digit strobe SHALL assert outRegLoad and move to EXEC. An op strobe SHALL overwrite outAluOp and stay in WAIT_B.
REQ-011 EXEC: outSelect=1 for exactly one cycle. outAcc SHALL load inMux, and outOverflow SHALL be ORed with inAluCarry. Next state is RESULT.
REQ-012 RESULT: outDone=1. An op strobe SHALL latch inOp and move to WAIT_B, chaining on the result. A digit strobe SHALL assert outRegLoad and go to LOAD_A, starting a new calculation.
REQ-013 outRegLoad SHALL be combinational: high only in the cycle an accepted digit strobe is present.
REQ-014 outSelect SHALL be decoded from state: 1 only in EXEC, 0 otherwise.
REQ-015 outBusy SHALL be 1 in LOAD_A and EXEC. Digit and op strobes arriving while outBusy=1 SHALL be ignored; inClear still applies.
REQ-016 Latency: a digit accepted at edge N SHALL appear on outAcc after edge N+1. A result SHALL appear on outAcc one edge after the second operand's digit is accepted.
REQ-017 outAcc SHALL change only in LOAD_A, EXEC, clear or reset; it holds in every other case.
REQ-018 The block SHALL perform no arithmetic. Width handling (zero-extension, ALU result width) belongs to the mux and ALU; outAcc loads all WIDTH bits unmodified.

Reset
REQ-019 inResetN=0 SHALL immediately set state=IDLE, outAcc=0, outAluOp=0 and outOverflow=0, independent of inClk.
REQ-020 While in reset, outSelect, outRegLoad, outBusy and outDone SHALL be 0. Strobes SHALL be ignored until the first edge after inResetN rises.
REQ-021 Reset asserted mid-operation (e.g. in EXEC) SHALL discard the pending ACC load and return to IDLE.

Verification
REQ-022 Sequence digit 3, op 00, digit 5, with the ALU model returning 8 -> outAcc=3 after LOAD_A; outSelect=1 for one cycle; outAcc=8 with outDone=1 and outOverflow=0.
REQ-023 Chaining: from RESULT with outAcc=8, op 01, digit 2, ALU returns 6 -> outAcc=6 and outAluOp=01.
REQ-024 Overflow: EXEC with inAluCarry=1 -> outOverflow=1. It stays 1 through a chained op, and clears on the next LOAD_A or on clear.
REQ-025 Simultaneous inClear and inDigitValid in WAIT_B -> IDLE with outAcc=0 and outRegLoad=0.
REQ-026 Digit strobe during LOAD_A (outBusy=1) -> ignored, with no outRegLoad pulse. Op strobe in IDLE -> ignored, with outAluOp unchanged.
REQ-027 inResetN pulsed low for less than one clock period in EXEC -> outAcc=0 and state IDLE immediately, with no ALU value loaded.
